bin_updown_counter: RTL

- 4-bit up/down counter with start/stop control and a built-in prescaler. Produces the 0..15 binary value that the downstream binary-to-BCD converter splits into two BCD digits for the 7-segment display path.
- Sits between the button front end (debounce/one-pulse, already producing single-cycle pulses) and the BCD conversion stage.

---
 rtl/bin_updown_counter_pkg.sv | 26 ++
 rtl/bin_updown_counter_freq_div_tick.sv | 50 +++++
 rtl/bin_updown_counter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bin_updown_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bin_updown_counter_pkg
//  Brief    : Shared state encoding and constants for the 4-bit up/down
//             counter and its prescaler.
//  Revision : 1.0  initial release
// ============================================================================
package bin_updown_counter_pkg;

   // Run/stop state of the counter FSM
   typedef enum logic [0:0] {
      STAT_STOP = 1'b0,
      STAT_RUN  = 1'b1
   } state_e;

   localparam logic [3:0] c_BIN_MAX    = 4'd15;
   localparam logic [3:0] c_BIN_MIN    = 4'd0;

   localparam logic       c_COUNT_UP   = 1'b1;
   localparam logic       c_COUNT_DOWN = 1'b0;

   localparam logic       c_ENABLED    = 1'b1;
   localparam logic       c_DISABLED   = 1'b0;

endpackage : bin_updown_counter_pkg
`default_nettype wire

// File: rtl/bin_updown_counter_freq_div_tick.sv
`default_nettype none
// ============================================================================
//  Module   : freq_div_tick
//  Brief    : Prescaler producing a one-cycle tick every DIV enabled clocks.
//             The count is forced to 0 whenever enable is low, so the first
//             tick after enabling arrives exactly DIV cycles later.
//  Revision : 1.0  initial release
// ============================================================================
module freq_div_tick #(
   parameter int DIV   = 4,
   parameter int CNT_W = 27
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   output logic tick
);
   import bin_updown_counter_pkg::*;

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick is combinational so the consuming edge is the one that wraps cnt
   assign tick = (enable == c_ENABLED) && (cnt_q == c_CNT_LAST);

   // Next prescaler value: clear when disabled, wrap at DIV-1
   always_comb begin
      cnt_d = cnt_q;
      if (enable == c_DISABLED) begin
         cnt_d = '0;
      end else if (cnt_q == c_CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Prescaler register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : freq_div_tick
`default_nettype wire

// File: rtl/bin_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bin_updown_counter
//  Brief    : 4-bit up/down counter with start/stop control and built-in
//             prescaler; feeds the binary-to-BCD converter.
//  Options  : COUNTER_SATURATE_EN - saturate at 15/0 instead of wrapping,
//             pulse wrap at the limit and drop back to STOP.
//  Revision : 1.0  initial release
// ============================================================================
module bin_updown_counter
   import bin_updown_counter_pkg::*;
#(
   parameter int DIV   = 100_000_000,
   parameter int CNT_W = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       up_down,
   output logic [3:0] bin,
   output logic       running,
   output logic       wrap
);

   state_e     state_q;
   state_e     state_d;
   logic [3:0] bin_q;
   logic [3:0] bin_d;
   logic       wrap_q;
   logic       wrap_d;

   logic       w_tick;
   logic       w_presc_en;
   logic       w_at_limit;
   logic       w_count_up;

   // Prescaler only runs while the registered state is RUN
   assign w_presc_en = (state_q == STAT_RUN) ? c_ENABLED : c_DISABLED;

   freq_div_tick #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_freq_div_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (w_presc_en),
      .tick   (w_tick)
   );

   // Direction is sampled live at each tick; the limit is the value the
   // next step in that direction would cross
   assign w_count_up = (up_down == c_COUNT_UP);
   assign w_at_limit = w_count_up ? (bin_q == c_BIN_MAX) : (bin_q == c_BIN_MIN);

   // Next-state logic: start_stop toggles; saturating build auto-stops at limit
   always_comb begin
      state_d = state_q;
      case (state_q)
         STAT_STOP: begin
            if (start_stop) begin
               state_d = STAT_RUN;
            end
         end
         STAT_RUN: begin
            if (start_stop) begin
               state_d = STAT_STOP;
            end
`ifdef COUNTER_SATURATE_EN
            else if (w_tick && w_at_limit) begin
               state_d = STAT_STOP;
            end
`endif
         end
         default: state_d = STAT_STOP;
      endcase
   end

   // Count datapath: load only in STOP, step only on tick in RUN
   always_comb begin
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (state_q == STAT_STOP) begin
         if (load) begin
            bin_d = load_val;
         end
      end else if (w_tick) begin
`ifdef COUNTER_SATURATE_EN
         if (w_at_limit) begin
            wrap_d = 1'b1;
         end else begin
            bin_d = w_count_up ? (bin_q + 4'd1) : (bin_q - 4'd1);
         end
`else
         bin_d  = w_count_up ? (bin_q + 4'd1) : (bin_q - 4'd1);
         wrap_d = w_at_limit;
`endif
      end
   end

   // State and output registers; reset overrides every other input
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= STAT_STOP;
         bin_q   <= c_BIN_MIN;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bin     = bin_q;
   assign running = (state_q == STAT_RUN);
   assign wrap    = wrap_q;

endmodule : bin_updown_counter
`default_nettype wire
